// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, E0, F0, E0F0} ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // Start low, stop high, odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [10:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible while not empty.
module ps2_key_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));

  // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside it.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_wr && !do_rd) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (do_rd && !do_wr) begin
        count_q <= count_q - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 frame checker and E0/F0 prefix folder feeding a key-event FIFO.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] frame,
  input  logic        frame_stb,
  input  logic        rd_en,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_brk,
  output logic        key_empty,
  output logic        key_full,
  output logic        ovf,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  input  logic        clr_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] tmo_cnt_q;
  logic [7:0]    data;
  logic          good, bad_stb, expire, wr_en;
  key_evt_t      wr_evt, head;

  assign data    = frame[8:1];
  assign good    = frame_ok(frame);
  assign bad_stb = frame_stb && !good;
  // A strobe on the last counted cycle reloads the timer, so the pending prefix survives.
  assign expire  = !frame_stb && (tmo_cnt_q == TW'(1));

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_evt  = '{ext: 1'b0, brk: 1'b0, code: data};
    if (frame_stb) begin
      if (!good) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (data == PS2_EXT)      state_d = E0;
            else if (data == PS2_BRK) state_d = F0;
            else                      wr_en   = 1'b1;
          end
          E0: begin
            if (data == PS2_BRK)      state_d = E0F0;
            else if (data != PS2_EXT) begin
              wr_en      = 1'b1;
              wr_evt.ext = 1'b1;
              state_d    = IDLE;
            end
          end
          F0: begin
            state_d = IDLE;
            if (data != PS2_EXT && data != PS2_BRK) begin
              wr_en      = 1'b1;
              wr_evt.brk = 1'b1;
            end
          end
          E0F0: begin
            state_d = IDLE;
            if (data != PS2_EXT && data != PS2_BRK) begin
              wr_en      = 1'b1;
              wr_evt.ext = 1'b1;
              wr_evt.brk = 1'b1;
            end
          end
        endcase
      end
    end else if (expire) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (frame_stb) begin
        tmo_cnt_q <= TW'(TIMEOUT_CYC);
      end else if (tmo_cnt_q != '0) begin
        tmo_cnt_q <= tmo_cnt_q - TW'(1);
      end
    end
  end

  // Clear takes priority: an error or drop in the clearing cycle is forgotten.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      ovf       <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (bad_stb) begin
        frame_err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      if (wr_en && key_full && !rd_en) begin
        ovf <= 1'b1;
      end
    end
  end

  ps2_key_fifo #(
    .WIDTH($bits(key_evt_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_evt),
    .rd_en  (rd_en),
    .rd_data(head),
    .empty  (key_empty),
    .full   (key_full)
  );

  assign key_code = head.code;
  assign key_ext  = head.ext;
  assign key_brk  = head.brk;

endmodule
